mux_rr_arbiter: RTL
===================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares the 64-bit 2:1 datapath multiplexer between two requesters.
- Each requester presents a data word with a valid/ready handshake.
- The arbiter picks one, drives the mux select and registers the chosen word into a single output stage with its own valid/ready handshake.
- It sits between two producers (e.g. ALU result and load data) and one consumer (e.g. register writeback).

Parameters:
- WIDTH, 64, data width of both requesters and the output.
- LOCK_MAX, 4, maximum consecutive beats one requester may hold the lock (used only with ARB_LOCK_EN).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid_0  input  1  requester 0 has a word.
- req_data_0  input  WIDTH  requester 0 word (mux data_0 leg).
- req_ready_0  output  1  requester 0 word accepted this cycle.
- req_valid_1  input  1  requester 1 has a word.
- req_data_1  input  WIDTH  requester 1 word (mux data_1 leg).
- req_ready_1  output  1  requester 1 word accepted this cycle.
- select  output  1  registered grant of the word in the output stage (0 = data_0, 1 = data_1).
- out_valid  output  1  output stage holds a word.
- out_data  output  WIDTH  registered mux output.
- out_ready  input  1  consumer takes the word.
- req_lock_0 / req_lock_1  input  1  lock request, present only with ARB_LOCK_EN.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - out_valid=0, out_data=0, select=0.
  - Round-robin pointer last=1, so requester 0 wins first.
  - Lock state cleared.
  - Words in flight are dropped.
- Acceptance window: accept = !out_valid || out_ready (the output stage is empty or draining this cycle).
- Combinational grant gnt, evaluated only when accept=1:
  - Only one valid: that requester.
  - Both valid: !last.
  - Neither valid: no grant.
- Ready outputs:
  - req_ready_x = accept && req_valid_x && gnt==x.
  - At most one ready high per cycle.
  - Ready never asserts without its valid.
- On the edge with a grant:
  - out_data takes the word from the mux with select=gnt.
  - select <= gnt; out_valid <= 1; last <= gnt.
- On the edge with no grant and out_ready && out_valid: out_valid <= 0. out_data and select hold their last values.
- Latency:
  - One cycle from acceptance to out_valid.
  - Full throughput of 1 word/cycle when out_ready is held high. A simultaneous drain and refill in the same cycle keeps out_valid=1.
- Stall: while out_valid && !out_ready, out_data and select are stable and both req_ready are 0.
- Fairness: with both requesters continuously valid and out_ready=1, grants alternate 0,1,0,1…
- Requester rules: a requester that drops valid before being readied loses nothing. Its arbitration turn is not reserved.

Optional Feature:
- Macro: ARB_LOCK_EN.
- With the macro defined:
  - The req_lock_0/1 ports exist.
  - If the granted requester's beat is accepted with req_lock_x=1, the arbiter locks to x. Following grants go only to x, regardless of the other requester's valid.
  - Release happens when x has a beat accepted with lock=0, or when LOCK_MAX consecutive locked beats have been accepted (forced release).
  - After release, last=x, so the other requester wins next if valid.
  - A lock counter (clog2(LOCK_MAX+1) bits) resets to 0.
- Without the macro: the ports are absent and behaviour is pure round-robin as above.

Decomposition:
- Package mux_arb_pkg holds:
  - WIDTH_DEFAULT=64.
  - LOCK_MAX_DEFAULT=4.
  - Grant typedef with GRANT_0=1'b0 and GRANT_1=1'b1.
- One natural sub-module, rr_pick2: a combinational two-way round-robin picker.
  - Inputs: valid[1:0], last, plus lock/owner under the macro.
  - Outputs: gnt, gnt_valid.
- The existing multiplexer is instantiated for the data path.

Test Plan:
- Reset: assert reset mid-stream with out_valid=1 -> out_valid=0, out_data=0, select=0 immediately (asynchronous). The first grant after reset goes to requester 0.
- Single requester: req_valid_0=1, req_data_0=64'hA5A5A5A5A5A5A5A5, out_ready=1 -> req_ready_0=1 in that cycle. Next cycle out_valid=1, out_data=64'hA5A5A5A5A5A5A5A5, select=0.
- Contention: both valid, data_0=64'h123456789ABCDEF0, data_1=64'hFEDCBA9876543210, out_ready=1 for 4 cycles -> select sequence 0,1,0,1 and out_data alternating accordingly.
- Back-pressure: out_ready=0 for 3 cycles with both valid -> out_data/select stable, req_ready_0=req_ready_1=0. Release out_ready -> the next grant goes to the requester not last served.
- Simultaneous drain/refill: out_valid=1, out_ready=1, req_valid_1=1 -> out_valid stays 1 and out_data updates to data_1 on the same edge.
- ARB_LOCK_EN build: requester 0 locked continuously while requester 1 is valid -> exactly 4 consecutive grants to 0, forced release, then a grant to 1.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// rtl/mux_rr_arbiter_pkg.sv - shared defaults and grant type for the round-robin mux arbiter (optional ARB_LOCK_EN)
package mux_arb_pkg;

   localparam int WIDTH_DEFAULT    = 64;
   localparam int LOCK_MAX_DEFAULT = 4;

   // Grant value doubles as the datapath mux select
   typedef enum logic {
      GRANT_0 = 1'b0,
      GRANT_1 = 1'b1
   } grant_t;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - requester and output handshake bundle; lock inputs exist only with ARB_LOCK_EN
interface mux_rr_arbiter_if #(
   parameter int WIDTH = mux_arb_pkg::WIDTH_DEFAULT
);
   logic             req_valid_0;
   logic [WIDTH-1:0] req_data_0;
   logic             req_ready_0;
   logic             req_valid_1;
   logic [WIDTH-1:0] req_data_1;
   logic             req_ready_1;
   logic             select;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
`ifdef ARB_LOCK_EN
   logic             req_lock_0;
   logic             req_lock_1;
`endif

   // Arbiter side
   modport slave (
      input  req_valid_0, req_data_0, req_valid_1, req_data_1, out_ready,
`ifdef ARB_LOCK_EN
      input  req_lock_0, req_lock_1,
`endif
      output req_ready_0, req_ready_1, select, out_valid, out_data
   );

   // Producer/consumer side
   modport master (
      output req_valid_0, req_data_0, req_valid_1, req_data_1, out_ready,
`ifdef ARB_LOCK_EN
      output req_lock_0, req_lock_1,
`endif
      input  req_ready_0, req_ready_1, select, out_valid, out_data
   );
endinterface

// File: rtl/mux_rr_arbiter_mux2.sv
// rtl/mux_rr_arbiter_mux2.sv - 2:1 datapath multiplexer shared by the two requesters
module mux2 #(
   parameter int WIDTH = mux_arb_pkg::WIDTH_DEFAULT
) (
   input  logic             i_sel,
   input  logic [WIDTH-1:0] i_data_0,
   input  logic [WIDTH-1:0] i_data_1,
   output logic [WIDTH-1:0] o_data
);
   assign o_data = i_sel ? i_data_1 : i_data_0;
endmodule

// File: rtl/mux_rr_arbiter_rr_pick2.sv
// rtl/mux_rr_arbiter_rr_pick2.sv - combinational two-way round-robin picker; lock override with ARB_LOCK_EN
module rr_pick2
   import mux_arb_pkg::*;
(
   input  logic [1:0] i_valid,
   input  grant_t     i_last,
`ifdef ARB_LOCK_EN
   input  logic       i_locked,
   input  grant_t     i_owner,
`endif
   output grant_t     o_gnt,
   output logic       o_gnt_valid
);
   // A locked owner pins the grant; otherwise the requester not served last wins a tie
   always_comb begin
      o_gnt       = GRANT_0;
      o_gnt_valid = 1'b0;
`ifdef ARB_LOCK_EN
      if (i_locked) begin
         o_gnt       = i_owner;
         o_gnt_valid = (i_owner == GRANT_1) ? i_valid[1] : i_valid[0];
      end else begin
`else
      begin
`endif
         case (i_valid)
            2'b01: begin
               o_gnt       = GRANT_0;
               o_gnt_valid = 1'b1;
            end
            2'b10: begin
               o_gnt       = GRANT_1;
               o_gnt_valid = 1'b1;
            end
            2'b11: begin
               o_gnt       = (i_last == GRANT_1) ? GRANT_0 : GRANT_1;
               o_gnt_valid = 1'b1;
            end
            default: begin
               o_gnt       = GRANT_0;
               o_gnt_valid = 1'b0;
            end
         endcase
      end
   end
endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter feeding one registered output stage; ARB_LOCK_EN adds bounded locking
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEFAULT,
   parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   mux_rr_arbiter_if.slave      bus
);
   logic             w_accept;
   logic             w_take;
   grant_t           w_gnt;
   logic             w_gnt_valid;
   logic [WIDTH-1:0] w_mux_data;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   grant_t           r_select;
   grant_t           r_last;

   // Output stage can take a word when empty or being drained this cycle
   assign w_accept = !r_out_valid || bus.out_ready;
   assign w_take   = w_accept && w_gnt_valid;

`ifdef ARB_LOCK_EN
   localparam int CW = $clog2(LOCK_MAX + 1);

   logic          r_locked;
   grant_t        r_owner;
   logic [CW-1:0] r_lock_cnt;
   logic [CW-1:0] w_cnt_inc;
   logic          w_lock_req;

   assign w_lock_req = (w_gnt == GRANT_1) ? bus.req_lock_1 : bus.req_lock_0;
   assign w_cnt_inc  = (r_locked ? r_lock_cnt : '0) + CW'(1);

   // Lock holds while beats arrive with lock set, up to LOCK_MAX beats in a row
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_locked   <= 1'b0;
         r_owner    <= GRANT_0;
         r_lock_cnt <= '0;
      end else if (w_take) begin
         if (w_lock_req && (w_cnt_inc != CW'(LOCK_MAX))) begin
            r_locked   <= 1'b1;
            r_owner    <= w_gnt;
            r_lock_cnt <= w_cnt_inc;
         end else begin
            r_locked   <= 1'b0;
            r_lock_cnt <= '0;
         end
      end
   end
`endif

   rr_pick2 u_pick (
      .i_valid     ({bus.req_valid_1, bus.req_valid_0}),
      .i_last      (r_last),
`ifdef ARB_LOCK_EN
      .i_locked    (r_locked),
      .i_owner     (r_owner),
`endif
      .o_gnt       (w_gnt),
      .o_gnt_valid (w_gnt_valid)
   );

   mux2 #(.WIDTH(WIDTH)) u_mux (
      .i_sel    (w_gnt),
      .i_data_0 (bus.req_data_0),
      .i_data_1 (bus.req_data_1),
      .o_data   (w_mux_data)
   );

   assign bus.req_ready_0 = w_take && bus.req_valid_0 && (w_gnt == GRANT_0);
   assign bus.req_ready_1 = w_take && bus.req_valid_1 && (w_gnt == GRANT_1);
   assign bus.select      = r_select;
   assign bus.out_valid   = r_out_valid;
   assign bus.out_data    = r_out_data;

   // Load the granted word, or empty the stage when drained with nothing to refill
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_select    <= GRANT_0;
         r_last      <= GRANT_1;
      end else if (w_take) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_mux_data;
         r_select    <= w_gnt;
         r_last      <= w_gnt;
      end else if (bus.out_ready && r_out_valid) begin
         r_out_valid <= 1'b0;
      end
   end
endmodule
